// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module      : instr_fetch
// Description : Fetch stage holding the PC and a word-addressed instruction
//               memory. It supports stall, branch bubble and a halt on opcode F.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch #(
    parameter int          IMEM_DEPTH = 16,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [15:0]                   branch_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [15:0]                   imem_wdata,
    output logic [15:0]                   PC,
    output logic [15:0]                   IR,
    output logic [15:0]                   IR_PC,
    output logic                          valid,
    output logic                          halted
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   ir_pc_q, ir_pc_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;

    logic [15:0]   mem_q [IMEM_DEPTH];
    logic [AW-1:0] rd_idx;
    logic [15:0]   fetch_word;

    // Higher PC bits are dropped so addresses alias modulo the memory size.
    assign rd_idx     = pc_q[AW:1];
    assign fetch_word = mem_q[rd_idx];

    // Contents survive reset; the read above sees the pre-write word.
    always_ff @(posedge clock) begin
        if (imem_we) begin
            mem_q[imem_addr] <= imem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            ir_pc_q  <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    pc_d    = branch_target & 16'hFFFE;
                    ir_d    = 16'h0000;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    ir_d    = fetch_word;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + 16'd2;
                    valid_d = 1'b1;
                    if (fetch_word[15:12] == 4'hF) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            S_HALT: begin
                // A stall keeps the halt instruction on offer; otherwise retire it.
                valid_d = valid_q & stall;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign PC     = pc_q;
    assign IR     = ir_q;
    assign IR_PC  = ir_pc_q;
    assign valid  = valid_q;
    assign halted = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, imem_we;
    logic [15:0] branch_target, imem_wdata;
    logic [3:0]  imem_addr;
    logic [15:0] PC, IR, IR_PC;
    logic        valid, halted;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] ir_pc;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t        sb_q[$];

    logic [15:0] m_mem [16];
    logic [15:0] m_pc, m_ir, m_irpc;
    logic        m_valid, m_halt;

    instr_fetch #(.IMEM_DEPTH(16), .RESET_PC(16'h0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .PC           (PC),
        .IR           (IR),
        .IR_PC        (IR_PC),
        .valid        (valid),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [15:0] tgt, input logic we,
                        input logic [3:0] wa, input logic [15:0] wd);
        exp_t        e;
        logic [15:0] w;
        reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
        imem_we = we; imem_addr = wa; imem_wdata = wd;
        if (rst) begin
            m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
            m_valid = 1'b0;  m_halt = 1'b0;
        end else if (m_halt) begin
            m_valid = m_valid && stl;
        end else if (br) begin
            m_pc = {tgt[15:1], 1'b0}; m_ir = 16'h0000; m_valid = 1'b0;
        end else if (!stl) begin
            w = m_mem[m_pc[4:1]];
            m_ir = w; m_irpc = m_pc; m_pc = m_pc + 16'd2; m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
        end
        if (we) m_mem[wa] = wd;
        e.pc = m_pc; e.ir = m_ir; e.ir_pc = m_irpc; e.valid = m_valid; e.halted = m_halt;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check("pc",     PC,            e.pc);
        check("ir",     IR,            e.ir);
        check("ir_pc",  IR_PC,         e.ir_pc);
        check("valid",  {15'd0, valid},  {15'd0, e.valid});
        check("halted", {15'd0, halted}, {15'd0, e.halted});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] init_data [4];
        init_data[0] = 16'h1234; init_data[1] = 16'h2345;
        init_data[2] = 16'h3456; init_data[3] = 16'h4567;
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_pc = 16'h0; m_ir = 16'h0; m_irpc = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        imem_we = 1'b0; imem_addr = 4'h0; imem_wdata = 16'h0;

        // Preload the whole memory under reset.
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 4'(i),
                 (i < 4) ? init_data[i] : 16'h0A00 + 16'(i));
        check("rst_pc", PC, 16'h0000);
        check("rst_valid", {15'd0, valid}, 16'h0000);

        // Sequential fetch
        run(1); check("f1_ir", IR, 16'h1234); check("f1_irpc", IR_PC, 16'h0000);
        run(1); check("f2_ir", IR, 16'h2345); check("f2_irpc", IR_PC, 16'h0002);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
        check("stall_ir", IR, 16'h2345); check("stall_pc", PC, 16'h0004);
        run(1); check("f3_ir", IR, 16'h3456); check("f3_irpc", IR_PC, 16'h0004);

        // Branch to odd target: bit 0 dropped, one bubble
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
        run(1); check("b_pre_ir", IR, 16'h1234);
        step(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 4'h0, 16'h0);
        check("b_valid", {15'd0, valid}, 16'h0000);
        check("b_ir", IR, 16'h0000); check("b_pc", PC, 16'h0006);
        run(1); check("b_tgt_ir", IR, 16'h4567); check("b_tgt_irpc", IR_PC, 16'h0006);

        // Branch beats stall
        step(1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 4'h0, 16'h0);
        check("bs_pc", PC, 16'h0002); check("bs_valid", {15'd0, valid}, 16'h0000);
        run(1); check("bs_ir", IR, 16'h2345);

        // Halt with a stall extending the halt instruction
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 4'h2, 16'hF000);
        run(3);
        check("h_ir", IR, 16'hF000); check("h_halted", {15'd0, halted}, 16'h0001);
        check("h_valid", {15'd0, valid}, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
        check("h_stall_valid", {15'd0, valid}, 16'h0001);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 4'h0, 16'h0);
        check("h_pc", PC, 16'h0006); check("h_valid0", {15'd0, valid}, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 4'h2, 16'h3456);
        check("h_rst_pc", PC, 16'h0000); check("h_rst_halt", {15'd0, halted}, 16'h0000);

        // Wrap past the top of memory, then read-first on a same-cycle write
        step(1'b0, 1'b0, 1'b1, 16'h001E, 1'b0, 4'h0, 16'h0);
        run(1); check("w_irpc", IR_PC, 16'h001E); check("w_pc", PC, 16'h0020);
        run(1); check("w_alias_ir", IR, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 4'h1, 16'hBEEF);
        check("rf_old", IR, 16'h2345);
        step(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 4'h0, 16'h0);
        run(1); check("rf_new", IR, 16'hBEEF);

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 16'($urandom),
                 ($urandom_range(0, 3) == 0), 4'($urandom),
                 ($urandom_range(0, 9) == 0) ? 16'hF00D : {4'h1, 12'($urandom)});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
